// File: rtl/legup_st_packet_channel_arbiter.sv
// Packet-level round-robin arbiter: locks one Avalon-ST source for a whole packet
// and tags each registered output beat with the granted source index.
module legup_st_packet_channel_arbiter #(
  parameter int NUM_IN    = 4,
  parameter int DATA_W    = 8,
  parameter int CHANNEL_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic [NUM_IN*DATA_W-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_startofpacket,
  input  logic [NUM_IN-1:0]        in_endofpacket,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [CHANNEL_W-1:0]     out_channel,
  output logic                     busy,
  output logic                     err_sop
);

  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic                first_q, first_d;
  logic                err_q, err_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_sop_q, out_sop_d;
  logic                out_eop_q, out_eop_d;
  logic [CHANNEL_W-1:0] out_chan_q, out_chan_d;

  logic [IDX_W:0]      cand_w_s;
  logic [IDX_W-1:0]    cand_s;
  logic [IDX_W-1:0]    pick_idx_s;
  logic                pick_found_s;
  logic                sel_valid_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic                sel_sop_s;
  logic                sel_eop_s;
  logic                room_s;
  logic                accept_s;
  logic [IDX_W-1:0]    next_ptr_s;

  // Round-robin pick: scan from the highest offset down so the lowest offset
  // from rr_ptr is the final (winning) assignment.
  always_comb begin
    pick_idx_s   = '0;
    pick_found_s = 1'b0;
    cand_w_s     = '0;
    cand_s       = '0;
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      cand_w_s = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand_w_s >= (IDX_W+1)'(NUM_IN)) begin
        cand_w_s = cand_w_s - (IDX_W+1)'(NUM_IN);
      end else begin
        cand_w_s = cand_w_s;
      end
      cand_s       = cand_w_s[IDX_W-1:0];
      pick_idx_s   = in_valid[cand_s] ? cand_s : pick_idx_s;
      pick_found_s = pick_found_s | in_valid[cand_s];
    end
  end

  assign sel_valid_s = in_valid[grant_q];
  assign sel_data_s  = in_data[int'(grant_q)*DATA_W +: DATA_W];
  assign sel_sop_s   = in_startofpacket[grant_q];
  assign sel_eop_s   = in_endofpacket[grant_q];
  assign room_s      = ~out_valid_q | out_ready;
  assign next_ptr_s  = (grant_q == IDX_W'(NUM_IN - 1)) ? '0 : grant_q + IDX_W'(1);

  // Next-state, handshake and output-register load logic.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    first_d     = first_q;
    err_d       = err_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_chan_d  = out_chan_q;
    in_ready    = '0;
    accept_s    = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          grant_d = pick_idx_s;
          first_d = 1'b1;
          state_d = ST_LOCKED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        in_ready[grant_q] = room_s;
        accept_s          = sel_valid_s & room_s;
        if (accept_s) begin
          out_valid_d = 1'b1;
          out_data_d  = sel_data_s;
          out_sop_d   = sel_sop_s;
          out_eop_d   = sel_eop_s;
          out_chan_d  = CHANNEL_W'(grant_q);
          first_d     = 1'b0;
          // Missing SOP on the first beat, or a stray SOP later, is sticky.
          err_d       = err_q | (first_q ^ sel_sop_s);
          if (sel_eop_s) begin
            state_d  = ST_IDLE;
            rr_ptr_d = next_ptr_s;
          end else begin
            state_d  = ST_LOCKED;
          end
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      first_q     <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_chan_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      first_q     <= first_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;
  assign out_channel       = out_chan_q;
  assign busy              = (state_q == ST_LOCKED);
  assign err_sop           = err_q;

endmodule

// File: tb/tb_legup_st_packet_channel_arbiter.sv
// Directed bench for legup_st_packet_channel_arbiter: per-source beat queues feed
// the inputs, accepted output beats are logged, and each scenario task checks inline.
module tb_legup_st_packet_channel_arbiter;

  localparam int NUM_IN = 4;
  localparam int DATA_W = 8;
  localparam int CHANNEL_W = 8;

  logic                     clk;
  logic                     reset_n;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN-1:0]        in_ready;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_startofpacket;
  logic [NUM_IN-1:0]        in_endofpacket;
  logic                     out_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_startofpacket;
  logic                     out_endofpacket;
  logic [CHANNEL_W-1:0]     out_channel;
  logic                     busy;
  logic                     err_sop;

  int n_tests = 0;
  int n_fail  = 0;

  logic [9:0]  src_mem [NUM_IN][16];
  int          src_rd [NUM_IN];
  int          src_wr [NUM_IN];
  logic [17:0] out_log [$];
  logic [NUM_IN-1:0] hs_s;

  legup_st_packet_channel_arbiter #(
    .NUM_IN(NUM_IN), .DATA_W(DATA_W), .CHANNEL_W(CHANNEL_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
    .out_channel(out_channel), .busy(busy), .err_sop(err_sop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source model and output logger: handshakes sampled mid-cycle, inputs updated 1 after the edge.
  initial begin
    in_valid = '0; in_data = '0; in_startofpacket = '0; in_endofpacket = '0;
    for (int s = 0; s < NUM_IN; s++) begin src_rd[s] = 0; src_wr[s] = 0; end
    forever begin
      @(negedge clk);
      hs_s = in_valid & in_ready & {NUM_IN{reset_n}};
      if (out_valid && out_ready && reset_n)
        out_log.push_back({out_channel, out_startofpacket, out_endofpacket, out_data});
      @(posedge clk);
      #1;
      for (int s = 0; s < NUM_IN; s++) begin
        if (hs_s[s]) src_rd[s] = src_rd[s] + 1;
        if (src_rd[s] < src_wr[s]) begin
          in_valid[s] = 1'b1;
          {in_startofpacket[s], in_endofpacket[s], in_data[s*DATA_W +: DATA_W]} = src_mem[s][src_rd[s]];
        end else begin
          in_valid[s] = 1'b0;
          in_startofpacket[s] = 1'b0;
          in_endofpacket[s] = 1'b0;
          in_data[s*DATA_W +: DATA_W] = 8'h00;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_beat(input int s, input logic sop, input logic eop, input logic [7:0] d);
    src_mem[s][src_wr[s]] = {sop, eop, d};
    src_wr[s] = src_wr[s] + 1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    for (int s = 0; s < NUM_IN; s++) begin src_rd[s] = 0; src_wr[s] = 0; end
    out_log.delete();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_log(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget && out_log.size() < n; c++) tick();
    if (out_log.size() >= n) ok = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({out_valid, out_data, out_startofpacket, out_endofpacket, out_channel, busy, err_sop, in_ready} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_state got v=%b d=%h s=%b e=%b ch=%h busy=%b err=%b rdy=%b, expected all zero",
               out_valid, out_data, out_startofpacket, out_endofpacket, out_channel, busy, err_sop, in_ready);
    end
  endtask

  task automatic test_single_source();
    do_reset();
    push_beat(2, 1'b1, 1'b0, 8'h11);
    push_beat(2, 1'b0, 1'b0, 8'h22);
    push_beat(2, 1'b0, 1'b1, 8'h33);
    tick();
    n_tests++;
    if ({in_valid[2], out_valid, busy} !== 3'b100) begin
      n_fail++; $display("FAIL single_t0 got valid2/out_valid/busy=%b expected 100", {in_valid[2], out_valid, busy});
    end
    tick();
    n_tests++;
    if ({busy, out_valid, in_ready} !== 6'b10_0100) begin
      n_fail++; $display("FAIL single_grant got busy/out_valid/in_ready=%b expected 100100", {busy, out_valid, in_ready});
    end
    tick();
    n_tests++;
    if ({out_valid, out_channel, out_startofpacket, out_endofpacket, out_data} !== {1'b1, 8'd2, 1'b1, 1'b0, 8'h11}) begin
      n_fail++; $display("FAIL single_beat1 got v=%b ch=%0d s=%b e=%b d=%h expected 1/2/1/0/11",
                         out_valid, out_channel, out_startofpacket, out_endofpacket, out_data);
    end
    tick();
    n_tests++;
    if ({out_valid, out_channel, out_startofpacket, out_endofpacket, out_data} !== {1'b1, 8'd2, 1'b0, 1'b0, 8'h22}) begin
      n_fail++; $display("FAIL single_beat2 got v=%b ch=%0d s=%b e=%b d=%h expected 1/2/0/0/22",
                         out_valid, out_channel, out_startofpacket, out_endofpacket, out_data);
    end
    tick();
    n_tests++;
    if ({out_valid, out_channel, out_startofpacket, out_endofpacket, out_data, busy} !== {1'b1, 8'd2, 1'b0, 1'b1, 8'h33, 1'b0}) begin
      n_fail++; $display("FAIL single_beat3 got v=%b ch=%0d s=%b e=%b d=%h busy=%b expected 1/2/0/1/33/0",
                         out_valid, out_channel, out_startofpacket, out_endofpacket, out_data, busy);
    end
    tick();
    n_tests++;
    if ({out_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL single_drain got out_valid/busy=%b expected 00", {out_valid, busy});
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [17:0] exp;
    int s, p, b;
    do_reset();
    for (int pk = 0; pk < 2; pk++)
      for (int src = 0; src < NUM_IN; src++) begin
        push_beat(src, 1'b1, 1'b0, 8'(src*16 + pk*2));
        push_beat(src, 1'b0, 1'b1, 8'(src*16 + pk*2 + 1));
      end
    wait_log(16, 200, ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL rr_timeout got %0d beats expected 16", out_log.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        s = (i / 2) % NUM_IN; p = i / 8; b = i % 2;
        exp = {8'(s), (b == 0), (b == 1), 8'(s*16 + p*2 + b)};
        n_tests++;
        if (out_log[i] !== exp) begin
          n_fail++; $display("FAIL rr_beat%0d got %h expected %h", i, out_log[i], exp);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    push_beat(1, 1'b1, 1'b0, 8'hB1);
    push_beat(1, 1'b0, 1'b0, 8'hB2);
    push_beat(1, 1'b0, 1'b0, 8'hB3);
    push_beat(1, 1'b0, 1'b1, 8'hB4);
    tick(); tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #1;
    n_tests++;
    if ({out_valid, out_data, in_ready[1]} !== {1'b1, 8'hB1, 1'b0}) begin
      n_fail++; $display("FAIL bp_first got v=%b d=%h rdy1=%b expected 1/b1/0", out_valid, out_data, in_ready[1]);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_tests++;
      if ({out_valid, out_data, out_startofpacket, out_endofpacket, out_channel, in_ready[1]} !== {1'b1, 8'hB1, 1'b1, 1'b0, 8'd1, 1'b0}) begin
        n_fail++; $display("FAIL bp_hold%0d got v=%b d=%h s=%b e=%b ch=%0d rdy1=%b expected 1/b1/1/0/1/0",
                           c, out_valid, out_data, out_startofpacket, out_endofpacket, out_channel, in_ready[1]);
      end
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (in_ready[1] !== 1'b1) begin
      n_fail++; $display("FAIL bp_release got rdy1=%b expected 1", in_ready[1]);
    end
    wait_log(4, 30, ok);
    tick(); tick();
    n_tests++;
    if (!ok || out_log.size() != 4) begin
      n_fail++; $display("FAIL bp_count got %0d beats expected 4", out_log.size());
    end else begin
      n_tests++;
      if ({out_log[0], out_log[1], out_log[2], out_log[3]} !==
          {8'd1, 2'b10, 8'hB1, 8'd1, 2'b00, 8'hB2, 8'd1, 2'b00, 8'hB3, 8'd1, 2'b01, 8'hB4}) begin
        n_fail++; $display("FAIL bp_seq got %h %h %h %h expected 1_2b1 1_0b2 1_0b3 1_1b4",
                           out_log[0], out_log[1], out_log[2], out_log[3]);
      end
    end
  endtask

  task automatic test_single_beat();
    bit ok;
    do_reset();
    push_beat(0, 1'b1, 1'b1, 8'hA5);
    push_beat(3, 1'b1, 1'b1, 8'h5A);
    wait_log(2, 30, ok);
    tick(); tick();
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL sb_timeout got %0d beats expected 2", out_log.size());
    end else begin
      n_tests++;
      if ({out_log[0], out_log[1]} !== {8'd0, 2'b11, 8'hA5, 8'd3, 2'b11, 8'h5A}) begin
        n_fail++; $display("FAIL sb_seq got %h %h expected 0_3a5 3_35a", out_log[0], out_log[1]);
      end
    end
    n_tests++;
    if ({busy, out_valid, out_log.size() == 2} !== 3'b001) begin
      n_fail++; $display("FAIL sb_idle got busy=%b out_valid=%b beats=%0d expected 0/0/2", busy, out_valid, out_log.size());
    end
  endtask

  task automatic test_protocol_error();
    bit ok;
    do_reset();
    push_beat(1, 1'b0, 1'b0, 8'h31);
    push_beat(1, 1'b0, 1'b1, 8'h32);
    wait_log(2, 30, ok);
    tick(); tick(); tick();
    n_tests++;
    if (!ok || out_log[0] !== {8'd1, 2'b00, 8'h31} || out_log[1] !== {8'd1, 2'b01, 8'h32}) begin
      n_fail++; $display("FAIL perr_fwd got %0d beats first=%h expected 2 beats 1_031 1_132", out_log.size(), out_log[0]);
    end
    n_tests++;
    if ({err_sop, busy} !== 2'b10) begin
      n_fail++; $display("FAIL perr_sticky got err=%b busy=%b expected 1/0", err_sop, busy);
    end
    do_reset();
    n_tests++;
    if (err_sop !== 1'b0) begin
      n_fail++; $display("FAIL perr_clear got err=%b expected 0", err_sop);
    end
    push_beat(2, 1'b1, 1'b0, 8'h41);
    push_beat(2, 1'b1, 1'b1, 8'h42);
    wait_log(2, 30, ok);
    tick();
    n_tests++;
    if ({ok, err_sop} !== 2'b11) begin
      n_fail++; $display("FAIL perr_late_sop got done/err=%b expected 11", {ok, err_sop});
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int c;
    do_reset();
    push_beat(2, 1'b1, 1'b1, 8'h2E);
    wait_log(1, 30, ok);
    tick(); tick();
    for (int k = 0; k < 5; k++) push_beat(3, k == 0, k == 4, 8'(8'hC1 + k));
    c = 0;
    while (!(out_valid && out_data == 8'hC2) && c < 30) begin tick(); c++; end
    n_tests++;
    if (c >= 30) begin
      n_fail++; $display("FAIL rmid_timeout got out_data=%h expected c2", out_data);
    end
    do_reset();
    n_tests++;
    if ({out_valid, busy, in_ready} !== 6'd0) begin
      n_fail++; $display("FAIL rmid_state got v=%b busy=%b rdy=%b expected 0/0/0000", out_valid, busy, in_ready);
    end
    push_beat(3, 1'b1, 1'b1, 8'hD3);
    push_beat(1, 1'b1, 1'b1, 8'hD1);
    wait_log(2, 30, ok);
    n_tests++;
    if (!ok || {out_log[0], out_log[1]} !== {8'd1, 2'b11, 8'hD1, 8'd3, 2'b11, 8'hD3}) begin
      n_fail++; $display("FAIL rmid_regrant got %0d beats first=%h expected 1_3d1 then 3_3d3", out_log.size(), out_log[0]);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    out_ready = 1'b1;
    tick();
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_single_beat();
    test_protocol_error();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
